// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory port, decode-side control and the IF/ID register outputs.
// The master side is driven by fetch_stage; the slave side belongs to imem/decode.
interface fetch_stage_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [INST_WIDTH-1:0] imem_inst;
  logic                  stall;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  if_id_valid;
  logic [ADDR_WIDTH-1:0] if_id_pc;
  logic [ADDR_WIDTH-1:0] if_id_pc_plus4;
  logic [INST_WIDTH-1:0] if_id_inst;
  logic                  fault;
  logic [ADDR_WIDTH-1:0] fault_addr;
  logic [31:0]           fetch_count;

  modport master (
    output imem_addr, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_inst,
           fault, fault_addr, fetch_count,
    input  imem_inst, stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_addr, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_inst,
           fault, fault_addr, fetch_count,
    output imem_inst, stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32 instruction fetch: PC register, combinational imem address, IF/ID capture one edge after addressing.
// stall holds PC and IF/ID; an aligned redirect overrides stall and flushes; a misaligned one traps until reset.
module fetch_stage #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h0000_0013
) (
  input logic          clk,
  input logic          reset,
  fetch_stage_if.master fif
);

  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic                  if_id_valid;
  logic [ADDR_WIDTH-1:0] if_id_pc;
  logic [ADDR_WIDTH-1:0] if_id_pc_plus4;
  logic [INST_WIDTH-1:0] if_id_inst;
  logic                  fault;
  logic [ADDR_WIDTH-1:0] fault_addr;
  logic [31:0]           fetch_count;

  // Wraps modulo 2^ADDR_WIDTH; the top word simply rolls over to address 0.
  assign pc_plus4 = pc + ADDR_WIDTH'(4);

  assign fif.imem_addr      = pc;
  assign fif.if_id_valid    = if_id_valid;
  assign fif.if_id_pc       = if_id_pc;
  assign fif.if_id_pc_plus4 = if_id_pc_plus4;
  assign fif.if_id_inst     = if_id_inst;
  assign fif.fault          = fault;
  assign fif.fault_addr     = fault_addr;
  assign fif.fetch_count    = fetch_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= BOOT;
      pc             <= RESET_PC;
      if_id_valid    <= 1'b0;
      if_id_pc       <= '0;
      if_id_pc_plus4 <= '0;
      if_id_inst     <= NOP_INST;
      fault          <= 1'b0;
      fault_addr     <= '0;
      fetch_count    <= '0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (fif.redirect_valid && (fif.redirect_pc[1:0] != 2'b00)) begin
            state       <= FAULT;
            fault       <= 1'b1;
            fault_addr  <= fif.redirect_pc;
            if_id_valid <= 1'b0;
            if_id_inst  <= NOP_INST;
          end else if (fif.redirect_valid) begin
            // Flush leaves the stale IF/ID PC fields; only valid/inst are meaningful.
            pc          <= fif.redirect_pc;
            if_id_valid <= 1'b0;
            if_id_inst  <= NOP_INST;
          end else if (!fif.stall) begin
            if_id_valid    <= 1'b1;
            if_id_pc       <= pc;
            if_id_pc_plus4 <= pc_plus4;
            if_id_inst     <= fif.imem_inst;
            pc             <= pc_plus4;
            fetch_count    <= fetch_count + 32'd1;
          end
        end
        FAULT: state <= FAULT;
        default: state <= FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage against a cycle-level behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_stage_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) fif ();

  fetch_stage #(
    .ADDR_WIDTH(32), .INST_WIDTH(32),
    .RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .fif  (fif)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0: memf = 32'h0010_0093;
      32'h4: memf = 32'h0020_0113;
      32'h8: memf = 32'h0030_0193;
      32'hC: memf = 32'h0040_0213;
      default: memf = a ^ 32'h5A5A_0003;
    endcase
  endfunction

  always_comb fif.imem_inst = memf(fif.imem_addr);

  typedef struct {
    logic [31:0] addr, pc, pc4, inst, faddr, cnt;
    logic        valid, fault;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: plain variables, one call per rising edge.
  logic        m_booted, m_fault, m_valid;
  logic [31:0] m_pc, m_ipc, m_inst, m_faddr, m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_booted = 0; m_fault = 0; m_valid = 0;
    m_pc = 0; m_ipc = 0; m_inst = NOP; m_faddr = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input logic s, input logic rv, input logic [31:0] rp);
    if (!m_booted) m_booted = 1;
    else if (m_fault) begin end
    else if (rv && rp[1:0] != 2'b00) begin
      m_fault = 1; m_faddr = rp; m_valid = 0; m_inst = NOP;
    end else if (rv) begin
      m_pc = rp; m_valid = 0; m_inst = NOP;
    end else if (!s) begin
      m_valid = 1; m_ipc = m_pc; m_inst = memf(m_pc);
      m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
    end
  endtask

  // Drive inputs, let one edge happen, then queue what the outputs must show.
  task automatic step(input logic s, input logic rv, input logic [31:0] rp);
    exp_t e;
    fif.stall = s; fif.redirect_valid = rv; fif.redirect_pc = rp;
    model_edge(s, rv, rp);
    @(posedge clk); #1;
    e.addr = m_pc; e.pc = m_ipc; e.pc4 = m_ipc + 32'd4; e.inst = m_inst;
    e.faddr = m_faddr; e.cnt = m_cnt; e.valid = m_valid; e.fault = m_fault;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".imem_addr"}, fif.imem_addr, 32'h0);
    chk({tag, ".valid"}, {31'b0, fif.if_id_valid}, 32'h0);
    chk({tag, ".pc"}, fif.if_id_pc, 32'h0);
    chk({tag, ".pc4"}, fif.if_id_pc_plus4, 32'h0);
    chk({tag, ".inst"}, fif.if_id_inst, NOP);
    chk({tag, ".fault"}, {31'b0, fif.fault}, 32'h0);
    chk({tag, ".fault_addr"}, fif.fault_addr, 32'h0);
    chk({tag, ".count"}, fif.fetch_count, 32'h0);
  endtask

  // Assert reset between edges, after the monitor has consumed the last entry.
  task automatic async_reset(input string tag);
    #6;
    reset = 1'b1;
    #1;
    check_reset_values(tag);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Monitor: compares every cycle's outputs against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("imem_addr", fif.imem_addr, e.addr);
        chk("if_id_valid", {31'b0, fif.if_id_valid}, {31'b0, e.valid});
        chk("if_id_inst", fif.if_id_inst, e.inst);
        chk("fault", {31'b0, fif.fault}, {31'b0, e.fault});
        chk("fault_addr", fif.fault_addr, e.faddr);
        chk("fetch_count", fif.fetch_count, e.cnt);
        if (e.valid) begin
          chk("if_id_pc", fif.if_id_pc, e.pc);
          chk("if_id_pc_plus4", fif.if_id_pc_plus4, e.pc4);
        end
      end
    end
  end

  initial begin
    logic        s, r;
    logic [31:0] rp;
    reset = 1'b1;
    fif.stall = 0; fif.redirect_valid = 0; fif.redirect_pc = 0;
    #3;
    check_reset_values("por");
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;

    // Boot bubble then sequential fetch of words 0,4,8.
    step(0, 0, 0);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    // Stall holds everything for three cycles, then 0xC issues.
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    step(0, 0, 0);
    // Redirect overrides stall.
    step(1, 1, 32'h40);
    step(0, 0, 0); step(0, 0, 0);
    // Top-of-memory wrap.
    step(0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0); step(0, 0, 0);

    // Randomized segments separated by asynchronous resets.
    for (int seg = 0; seg < 4; seg++) begin
      async_reset("rst_seg");
      for (int i = 0; i < 60; i++) begin
        s  = ($urandom_range(0, 99) < 30);
        r  = ($urandom_range(0, 99) < 12);
        rp = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
        if ($urandom_range(0, 99) < 5) rp[1:0] = 2'($urandom_range(1, 3));
        step(s, r, rp);
      end
    end

    // Misaligned redirect traps and freezes until reset.
    async_reset("rst_pre_fault");
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    step(0, 1, 32'h42);
    step(0, 1, 32'h80); step(1, 0, 0); step(0, 0, 0); step(0, 1, 32'h43);
    async_reset("rst_post_fault");
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);

    @(negedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
